// File: rtl/pong_pkg.sv
// Shared definitions for the pong paddle path.
// FSM encoding, distance window defaults and paddle coordinate width.
package pong_pkg;

    localparam int Y_W        = 7;
    localparam int MIN_CM_DEF = 5;
    localparam int MAX_CM_DEF = 34;
    localparam int MISS_LIMIT = 8;

    typedef enum logic [1:0] {
        S_WAIT,
        S_CHECK,
        S_ACCUM,
        S_MAP
    } state_t;

endpackage

// File: rtl/paddle_slew.sv
// Rate limiter: moves paddle_y toward target_y by at most STEP
// per frame_tick, never overshooting so the range is preserved.
module paddle_slew
    import pong_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [Y_W-1:0] target_y,
    input  logic           frame_tick,
    output logic [Y_W-1:0] paddle_y
);

    logic [Y_W-1:0] gap;
    logic [Y_W-1:0] step;

    // distance to target, capped at STEP
    always_comb begin
        gap  = (target_y > paddle_y) ? target_y - paddle_y
                                     : paddle_y - target_y;
        step = (gap > Y_W'(STEP)) ? Y_W'(STEP) : gap;
    end

    // one bounded move per frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            paddle_y <= '0;
        end else if (frame_tick) begin
            if (target_y > paddle_y) begin
                paddle_y <= paddle_y + step;
            end else begin
                paddle_y <= paddle_y - step;
            end
        end
    end

endmodule

// File: rtl/paddle_tracker.sv
// Samples a raw hand distance, rejects glitches, averages four
// samples, maps to a paddle target and slews the paddle per frame.
module paddle_tracker
    import pong_pkg::*;
#(
    parameter int SAMPLE_CYCLES = 2500000,
    parameter int MIN_CM        = MIN_CM_DEF,
    parameter int MAX_CM        = MAX_CM_DEF,
    parameter int MAX_RAW       = 400,
    parameter int STEP          = 4
) (
    input  logic           CLOCK_50,
    input  logic           resetn,
    input  logic [9:0]     distance_in,
    input  logic           frame_tick,
    output logic [Y_W-1:0] paddle_y,
    output logic [Y_W-1:0] target_y,
    output logic           sample_done,
    output logic           no_hand
);

    localparam int CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam logic [CW-1:0] TC = CW'(SAMPLE_CYCLES - 1);

    logic [CW-1:0]  cnt;
    state_t         state;
    logic [9:0]     sample;
    logic [9:0]     hist [4];
    logic           primed;
    logic [11:0]    sum;
    logic [11:0]    sum_next;
    logic [3:0]     miss;
    logic           reject;
    logic [9:0]     avg;
    logic [9:0]     clamped;
    logic [Y_W-1:0] map_y;

    // free-running sample interval counter
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (cnt == TC) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // glitch test, running sum, clamp and map
    always_comb begin
        reject = (distance_in <= 10'd2) || (distance_in > 10'(MAX_RAW));
        if (primed) begin
            sum_next = {2'b00, sample} + {2'b00, hist[0]}
                     + {2'b00, hist[1]} + {2'b00, hist[2]};
        end else begin
            sum_next = {sample, 2'b00};
        end
        avg = 10'(sum >> 2);
        if (avg < 10'(MIN_CM)) begin
            clamped = 10'(MIN_CM);
        end else if (avg > 10'(MAX_CM)) begin
            clamped = 10'(MAX_CM);
        end else begin
            clamped = avg;
        end
        map_y = Y_W'((clamped - 10'(MIN_CM)) << 2);
    end

    // sample FSM with registered outputs
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state       <= S_WAIT;
            sample      <= '0;
            for (int i = 0; i < 4; i++) hist[i] <= '0;
            primed      <= 1'b0;
            sum         <= '0;
            miss        <= '0;
            target_y    <= '0;
            sample_done <= 1'b0;
            no_hand     <= 1'b0;
        end else begin
            sample_done <= 1'b0;
            unique case (state)
                S_WAIT: begin
                    if (cnt == TC) state <= S_CHECK;
                end
                S_CHECK: begin
                    sample <= distance_in;
                    if (reject) begin
                        state <= S_WAIT;
                        if (miss != 4'(MISS_LIMIT)) miss <= miss + 1'b1;
                        no_hand <= (miss >= 4'(MISS_LIMIT - 1));
                    end else begin
                        state   <= S_ACCUM;
                        miss    <= '0;
                        no_hand <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (primed) begin
                        hist[0] <= sample;
                        hist[1] <= hist[0];
                        hist[2] <= hist[1];
                        hist[3] <= hist[2];
                    end else begin
                        for (int i = 0; i < 4; i++) hist[i] <= sample;
                    end
                    primed <= 1'b1;
                    sum    <= sum_next;
                    state  <= S_MAP;
                end
                S_MAP: begin
                    target_y    <= map_y;
                    sample_done <= 1'b1;
                    state       <= S_WAIT;
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    paddle_slew #(
        .STEP(STEP)
    ) u_slew (
        .clk       (CLOCK_50),
        .rst_n     (resetn),
        .target_y  (target_y),
        .frame_tick(frame_tick),
        .paddle_y  (paddle_y)
    );

endmodule

// File: tb/tb_paddle_tracker.sv
// Directed bench for paddle_tracker with a 16-cycle sample period.
// Expected values are hand-computed from the averaging/mapping rules.
module tb_paddle_tracker;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [9:0] distance_in = 10'd0;
    logic       frame_tick = 1'b0;
    logic [6:0] paddle_y;
    logic [6:0] target_y;
    logic       sample_done;
    logic       no_hand;

    int vectors = 0;
    int errors  = 0;

    paddle_tracker #(
        .SAMPLE_CYCLES(16)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .distance_in(distance_in),
        .frame_tick (frame_tick),
        .paddle_y   (paddle_y),
        .target_y   (target_y),
        .sample_done(sample_done),
        .no_hand    (no_hand)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int d, input int n, output bit seen);
        distance_in = 10'(d);
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (sample_done) seen = 1'b1;
        end
    endtask

    task automatic sync(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (sample_done) ok = 1'b1;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    initial begin
        bit seen;
        bit any;
        bit ok;
        int n;
        int rej [8];
        rej = '{2, 500, 0, 1, 401, 1023, 2, 700};

        distance_in = 10'd20;
        repeat (2) @(negedge clk);
        chk("rst_paddle", paddle_y, 0);
        chk("rst_target", target_y, 0);
        chk("rst_done", sample_done, 0);
        chk("rst_nohand", no_hand, 0);

        resetn = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = sample_done;
        end
        chk("first_latency", n, 19);
        chk("t20", target_y, 60);
        ticks(14);
        chk("p14", paddle_y, 56);
        ticks(1);
        chk("p15", paddle_y, 60);
        ticks(1);
        chk("p_hold", paddle_y, 60);

        sync(ok);
        chk("sync_a", ok, 1);
        repeat (4) step(10, 16, seen);
        chk("t10x4", target_y, 20);
        step(30, 16, seen);
        chk("done30", seen, 1);
        chk("avg15", target_y, 40);

        step(2, 16, seen);
        chk("rej2_done", seen, 0);
        chk("rej2_t", target_y, 40);
        step(500, 16, seen);
        chk("rej500_done", seen, 0);
        chk("rej500_t", target_y, 40);

        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        any = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(rej[i], (i == 0) ? 19 : 16, seen);
            if (seen) any = 1'b1;
            if (i == 6) chk("nohand7", no_hand, 0);
        end
        chk("rej_any_done", any, 0);
        chk("nohand8", no_hand, 1);
        chk("rej_t0", target_y, 0);
        step(12, 16, seen);
        chk("done12", seen, 1);
        chk("nohand_clr", no_hand, 0);
        chk("t12", target_y, 28);

        step(3, 16, seen);
        chk("t3a", target_y, 16);
        repeat (3) step(3, 16, seen);
        chk("t3", target_y, 0);
        repeat (2) step(60, 16, seen);
        chk("t60b", target_y, 104);
        repeat (2) step(60, 16, seen);
        chk("t60", target_y, 116);

        ticks(29);
        chk("p_top", paddle_y, 116);
        sync(ok);
        chk("sync_b", ok, 1);
        repeat (4) step(3, 16, seen);
        chk("t_low", target_y, 0);
        ticks(1);
        chk("p112", paddle_y, 112);
        ticks(27);
        chk("p4", paddle_y, 4);
        ticks(1);
        chk("p0", paddle_y, 0);
        ticks(1);
        chk("p_nounder", paddle_y, 0);

        sync(ok);
        chk("sync_c", ok, 1);
        step(60, 16, seen);
        chk("t48", target_y, 48);
        ticks(2);
        chk("p8", paddle_y, 8);
        sync(ok);
        chk("sync_d", ok, 1);
        repeat (14) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("mid_paddle", paddle_y, 0);
        chk("mid_target", target_y, 0);
        chk("mid_done", sample_done, 0);
        chk("mid_nohand", no_hand, 0);
        @(negedge clk);
        resetn = 1'b1;
        step(25, 19, seen);
        chk("done25", seen, 1);
        chk("t25", target_y, 80);
        step(25, 16, seen);
        chk("t25b", target_y, 80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/paddle_tracker.md
PADDLE_TRACKER -- requirements
Module: paddle_tracker

Interface
REQ-001 SHALL have parameter SAMPLE_CYCLES, default 2500000, meaning clock cycles between distance samples (50 ms at 50 MHz).
REQ-002 SHALL have parameter MIN_CM, default 5, meaning the nearest hand distance, which maps to paddle_y = 0.
REQ-003 SHALL have parameter MAX_CM, default 34, meaning the farthest hand distance, which maps to the top of the paddle range.
REQ-004 SHALL have parameter MAX_RAW, default 400, meaning a raw distance above this value is rejected as a glitch.
REQ-005 SHALL have parameter STEP, default 4, meaning the maximum paddle_y change per frame_tick.
REQ-006 SHALL have port CLOCK_50, input, 1 bit: the single 50 MHz clock; all state on its rising edge.
REQ-007 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port distance_in, input, 10 bits: raw cm distance from the ultrasonic sensor stage, free-running and not handshaked.
REQ-009 SHALL have port frame_tick, input, 1 bit: one-cycle pulse once per video frame.
REQ-010 SHALL have port paddle_y, output, 7 bits: slewed paddle position, range 0..(MAX_CM-MIN_CM)*4.
REQ-011 SHALL have port target_y, output, 7 bits: filtered and mapped position before slew limiting.
REQ-012 SHALL have port sample_done, output, 1 bit: one-cycle pulse when target_y is updated.
REQ-013 SHALL have port no_hand, output, 1 bit: high while the last MISS_LIMIT=8 consecutive samples were all rejected.

Function
REQ-014 SHALL run a free counter 0..SAMPLE_CYCLES-1; at terminal count, the FSM leaves S_WAIT.
REQ-015 SHALL implement FSM states S_WAIT -> S_CHECK -> S_ACCUM -> S_MAP -> S_WAIT, each non-wait state lasting exactly one cycle.
REQ-016 S_CHECK SHALL register distance_in once; a sample is rejected if its value <= 2 (no-echo floor) or > MAX_RAW.
REQ-017 On a rejected sample, the FSM SHALL return to S_WAIT, increment the miss counter (saturating at 8), and leave target_y and the history unchanged, with no sample_done.
REQ-018 On an accepted sample, the miss counter SHALL clear and no_hand SHALL deassert on the same edge.
REQ-019 S_ACCUM SHALL shift the sample into a 4-entry history and compute a 12-bit sum; avg = sum >> 2 (truncate).
REQ-020 The first accepted sample after reset SHALL prime all 4 history entries with that value.
REQ-021 S_MAP SHALL clamp avg to [MIN_CM, MAX_CM], then set target_y = (clamped - MIN_CM) << 2, and pulse sample_done on the same edge.
REQ-022 Latency SHALL be 3 cycles from the terminal-count cycle to the target_y/sample_done edge.
REQ-023 On each frame_tick, paddle_y SHALL move toward target_y by min(STEP, |target_y - paddle_y|); if equal, it holds.
REQ-024 When frame_tick coincides with a target_y update, the slew SHALL use the pre-update target_y.
REQ-025 paddle_y SHALL never leave the range 0..(MAX_CM-MIN_CM)*4, with no wrap-around in the slew arithmetic.

Reset
REQ-026 resetn low SHALL asynchronously force: FSM S_WAIT, counter 0, history empty/unprimed, miss counter 0, target_y 0, paddle_y 0, sample_done 0, no_hand 0.
REQ-027 Reset asserted mid-sequence (any state) SHALL abandon the sample in flight; the first sample after release re-primes the history.

Structure
REQ-028 A shared package `pong_pkg` SHALL hold the FSM state encoding, MIN_CM/MAX_CM defaults, and the paddle coordinate width (7).
REQ-029 The slew limiter SHALL be a separate sub-module `paddle_slew` (inputs target_y and frame_tick; output paddle_y).
REQ-030 The design SHALL be fully synchronous with no derived clocks.

Verification
REQ-031 With SAMPLE_CYCLES=16, hold distance_in=20 -> first sample_done after 16+3 cycles, target_y=60; after 15 frame_ticks, paddle_y=60.
REQ-032 Accepted samples 10, 10, 10, 30 -> avg 15, target_y=40.
REQ-033 distance_in=2 then 500 -> no sample_done and target_y unchanged; 8 consecutive rejects -> no_hand=1; next sample of 12 -> no_hand=0, target_y=28.
REQ-034 distance_in=3 gives target_y=0; distance_in=60 gives target_y=116 (clamped).
REQ-035 With paddle_y=116 and target_y=0, each frame_tick decrements paddle_y by 4, reaching 0 after 29 ticks with no underflow.
REQ-036 Assert resetn during S_ACCUM -> all outputs are 0 immediately; after release, a sample of 25 gives target_y=80 (re-primed).
